// File: rtl/ssb_pkg.sv
// Shared types, constants and helpers for the SSB modulator.
//  - sample_t      : signed 16-bit audio sample
//  - SINE_LUT      : quarter-wave sine table, 256 x 16, amplitude 32767,
//                    entry k = round(32767 * sin(pi/2 * k/256))
//  - quarter_wave(): full-turn sine from the top LUT_AW+2 phase bits
//  - sat16()       : clamp a wide signed value to the 16-bit sample range
package ssb_pkg;

    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned LUT_AW     = 8;
    localparam int unsigned LUT_DEPTH  = 1 << LUT_AW;
    localparam int unsigned PROD_W     = 2 * SAMPLE_W;
    localparam int unsigned SUM_W      = PROD_W + 1;
    localparam int unsigned FRAC_SHIFT = 15;
    localparam int unsigned Q_FRAC     = 60;

    typedef logic signed [SAMPLE_W-1:0]    sample_t;
    typedef logic [LUT_DEPTH*SAMPLE_W-1:0] lut_t;

    localparam sample_t                 SINE_PEAK = 16'sd32767;
    // pi in Q60 (hex digits of pi: 3.243F6A8885A308D...)
    localparam logic signed [127:0]     PI_Q60    = 128'sh3243F6A8885A308D;
    localparam logic signed [SUM_W-1:0] SAT_HI    = SUM_W'(32767);
    localparam logic signed [SUM_W-1:0] SAT_LO    = ~SAT_HI;

    // Elaboration-time table build: Q60 Taylor series, rounded to nearest.
    function automatic lut_t sine_lut_init();
        lut_t                lut;
        logic signed [127:0] x, x2, term, acc, val;
        lut = '0;
        for (int k = 0; k < int'(LUT_DEPTH); k++) begin
            x    = (PI_Q60 * 128'(k)) >>> (LUT_AW + 1);
            x2   = (x * x) >>> Q_FRAC;
            term = x;
            acc  = x;
            for (int n = 1; n <= 12; n++) begin
                term = -((term * x2) >>> Q_FRAC) / 128'(2 * n * (2 * n + 1));
                acc  = acc + term;
            end
            val = (acc * 128'sd32767 + (128'sd1 <<< (Q_FRAC - 1))) >>> Q_FRAC;
            lut[k*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(val);
        end
        return lut;
    endfunction

    localparam lut_t SINE_LUT = sine_lut_init();

    function automatic sample_t sine_at(input logic [LUT_AW-1:0] idx);
        return sample_t'(SINE_LUT[32'(idx)*SAMPLE_W +: SAMPLE_W]);
    endfunction

    // Quadrant bits mirror (odd quadrants) and negate (upper half) the table.
    // Odd quadrant index 0 is the peak, which lies one past the table end.
    function automatic sample_t quarter_wave(input logic [LUT_AW+1:0] top);
        logic [LUT_AW-1:0] idx;
        sample_t           mag;
        idx = top[LUT_AW-1:0];
        if (top[LUT_AW]) begin
            mag = (idx == '0) ? SINE_PEAK : sine_at(LUT_AW'(0) - idx);
        end else begin
            mag = sine_at(idx);
        end
        return top[LUT_AW+1] ? -mag : mag;
    endfunction

    function automatic sample_t sat16(input logic signed [SUM_W-1:0] v);
        if (v > SAT_HI) return sample_t'(16'sh7FFF);
        if (v < SAT_LO) return sample_t'(16'sh8000);
        return sample_t'(v[SAMPLE_W-1:0]);
    endfunction

endpackage

// File: rtl/nco_sincos.sv
// Phase-accumulator NCO producing registered sin/cos, one step per sample.
//  clk, rst   : clock, synchronous active-high reset
//  step       : advance; sin/cos register the current phase, then phase += freq_word
//  freq_word  : phase increment applied after this step
//  sin, cos   : registered outputs, valid one cycle after step
module nco_sincos
    import ssb_pkg::*;
#(
    parameter int unsigned PHASE_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    input  logic [PHASE_W-1:0] freq_word,
    output sample_t            sin,
    output sample_t            cos
);

    localparam int unsigned TOP_W = LUT_AW + 2;

    logic [PHASE_W-1:0] phase;
    logic [TOP_W-1:0]   sin_top;
    logic [TOP_W-1:0]   cos_top;

    // Low phase bits are truncated; cos is sin a quarter turn ahead.
    assign sin_top = phase[PHASE_W-1 -: TOP_W];
    assign cos_top = sin_top + TOP_W'(1 << LUT_AW);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            sin   <= '0;
            cos   <= '0;
        end else if (step) begin
            phase <= phase + freq_word;
            sin   <= quarter_wave(sin_top);
            cos   <= quarter_wave(cos_top);
        end
    end

endmodule

// File: rtl/ssb_mixer.sv
// Single-sideband modulator: delays I by the Hilbert group delay, mixes I/Q
// with an internal NCO and emits one saturated sample per accepted input.
//  clk, rst   : clock, synchronous active-high reset
//  in_valid   : sample strobe for i_din/q_din/freq_word/usb
//  i_din      : raw PCM sample
//  q_din      : Hilbert output, aligned with i_din
//  freq_word  : NCO increment applied after this sample
//  usb        : 1 = I*cos - Q*sin (upper), 0 = I*cos + Q*sin (lower)
//  dout       : SSB sample, holds between strobes
//  out_valid  : one-cycle strobe, 3 cycles after the accepting in_valid
module ssb_mixer
    import ssb_pkg::*;
#(
    parameter int unsigned GROUP_DELAY = 15,
    parameter int unsigned PHASE_W     = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  sample_t            i_din,
    input  sample_t            q_din,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic               usb,
    output sample_t            dout,
    output logic               out_valid
);

    sample_t                  dly [GROUP_DELAY];
    sample_t                  nco_sin, nco_cos;
    sample_t                  i_s1, q_s1;
    logic                     usb_s1, valid_s1;
    logic signed [PROD_W-1:0] prod_cos_s2, prod_sin_s2;
    logic                     usb_s2, valid_s2;
    logic signed [SUM_W-1:0]  sum_c, scaled_c;

    nco_sincos #(.PHASE_W(PHASE_W)) u_nco (
        .clk       (clk),
        .rst       (rst),
        .step      (in_valid),
        .freq_word (freq_word),
        .sin       (nco_sin),
        .cos       (nco_cos)
    );

    // I delay line advances per accepted sample, not per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(GROUP_DELAY); k++) dly[k] <= '0;
        end else if (in_valid) begin
            dly[0] <= i_din;
            for (int k = 1; k < int'(GROUP_DELAY); k++) dly[k] <= dly[k-1];
        end
    end

    // Sideband combine, rescale from Q15 and clamp.
    always_comb begin
        sum_c    = usb_s2 ? (SUM_W'(prod_cos_s2) - SUM_W'(prod_sin_s2))
                          : (SUM_W'(prod_cos_s2) + SUM_W'(prod_sin_s2));
        scaled_c = sum_c >>> FRAC_SHIFT;
    end

    // S1 capture, S2 multiply, S3 saturate; sin/cos arrive with S1 from the NCO.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_s1        <= '0;
            q_s1        <= '0;
            usb_s1      <= 1'b0;
            valid_s1    <= 1'b0;
            prod_cos_s2 <= '0;
            prod_sin_s2 <= '0;
            usb_s2      <= 1'b0;
            valid_s2    <= 1'b0;
            dout        <= '0;
            out_valid   <= 1'b0;
        end else begin
            valid_s1  <= in_valid;
            valid_s2  <= valid_s1;
            out_valid <= valid_s2;
            if (in_valid) begin
                i_s1   <= dly[GROUP_DELAY-1];
                q_s1   <= q_din;
                usb_s1 <= usb;
            end
            if (valid_s1) begin
                prod_cos_s2 <= PROD_W'(i_s1) * PROD_W'(nco_cos);
                prod_sin_s2 <= PROD_W'(q_s1) * PROD_W'(nco_sin);
                usb_s2      <= usb_s1;
            end
            if (valid_s2) begin
                dout <= sat16(scaled_c);
            end
        end
    end

endmodule
